cp0: RTL and testbench

System-control coprocessor for the MIPS pipeline; it consumes the Timer `IRQ` lines and other hardware interrupt sources.
- Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts against synchronous exceptions reported by the pipeline, and raises a single request that redirects fetch to the handler.
- Sits beside the M stage: the pipeline reports the victim PC and exception code there, and the `mfc0`/`mtc0`/`eret` operations execute there.

---
 rtl/mips_defs.sv | 38 +++
 rtl/cp0_if.sv | 37 +++
 rtl/cp0.sv | 118 +++++++++++
 tb/tb_cp0.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS system-control definitions: CP0 register indices, exception
// codes, the exception entry address, CP0 field positions and the
// exception/ERET state encoding.
package mips_defs;

    // CP0 register indices used by mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Exception codes reported by the pipeline (0 = none / interrupt)
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exception entry address and default processor ID
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT = 32'h0000_2017;

    // Field bit positions inside SR and Cause
    localparam int unsigned SR_IE_BIT    = 0;
    localparam int unsigned SR_EXL_BIT   = 1;
    localparam int unsigned IM_LO        = 10;
    localparam int unsigned IM_HI        = 15;
    localparam int unsigned EXC_LO       = 2;
    localparam int unsigned EXC_HI       = 6;
    localparam int unsigned CAUSE_BD_BIT = 31;

    // Exception/ERET state; HANDLER is exactly SR.EXL = 1
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } exc_state_t;

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 bus. The pipeline (master) drives the M-stage register
// access, victim PC, exception code, eret and interrupt lines; CP0 (slave)
// returns read data, EPC, the redirect request, the handler address and
// its exception state for observation.
interface cp0_if;
    import mips_defs::*;

    logic [4:0]  RA;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] RD;
    logic [31:0] EPCOut;
    logic        IntReq;
    logic [31:0] HandlerPC;
    exc_state_t  DbgState;

    // Handshake: there is no valid/ready pair. IntReq is a combinational
    // level that is sampled by both CP0 and the pipeline at the same rising
    // edge; when high at that edge, the entry is taken and fetch redirects
    // to HandlerPC. mtc0 (WE) and eret (EXLClr) are single-cycle strobes.
    modport master (
        output RA, WA, WD, WE, VPC, BDIn, ExcCodeIn, EXLClr, HWInt,
        input  RD, EPCOut, IntReq, HandlerPC, DbgState
    );

    modport slave (
        input  RA, WA, WD, WE, VPC, BDIn, ExcCodeIn, EXLClr, HWInt,
        output RD, EPCOut, IntReq, HandlerPC, DbgState
    );

endinterface

// File: rtl/cp0.sv
// System-control coprocessor: SR, Cause, EPC, PRId. Arbitrates live hardware
// interrupts against M-stage synchronous exceptions and performs exception
// entry; executes mfc0/mtc0/eret in the M stage.
module cp0
    import mips_defs::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter logic [31:0] HANDLER = HANDLER_ADDR
) (
    input  logic  CLK,
    input  logic  RST,
    cp0_if.slave  io
);

    exc_state_t  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [29:0] epc_q, epc_d;

    logic        exl;
    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] vpc_adj;
    logic [31:0] rd;

    // Request arbitration, next-state computation and mfc0 read mux
    always_comb begin
        exl      = (state_q == ST_HANDLER);
        int_pend = (|(io.HWInt & im_q)) & ie_q & ~exl;
        exc_pend = (io.ExcCodeIn != EXC_INT) & ~exl;
        int_req  = int_pend | exc_pend;
        vpc_adj  = io.BDIn ? (io.VPC - 32'd4) : io.VPC;

        state_d = state_q;
        im_d    = im_q;
        ie_d    = ie_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        ip_d    = io.HWInt;

        if (int_req) begin
            // Entry wins over any concurrent eret or mtc0
            state_d = ST_HANDLER;
            bd_d    = io.BDIn;
            exc_d   = int_pend ? EXC_INT : io.ExcCodeIn;
            epc_d   = vpc_adj[31:2];
        end else begin
            if (io.WE) begin
                case (io.WA)
                    REG_SR: begin
                        im_d    = io.WD[IM_HI:IM_LO];
                        ie_d    = io.WD[SR_IE_BIT];
                        state_d = io.WD[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
                    end
                    REG_EPC: epc_d = io.WD[31:2];
                    default: ;
                endcase
            end
            if (io.EXLClr) begin
                state_d = ST_NORMAL;
            end
        end

        rd = '0;
        case (io.RA)
            REG_SR: begin
                rd[IM_HI:IM_LO] = im_q;
                rd[SR_EXL_BIT]  = exl;
                rd[SR_IE_BIT]   = ie_q;
            end
            REG_CAUSE: begin
                rd[CAUSE_BD_BIT]  = bd_q;
                rd[IM_HI:IM_LO]   = ip_q;
                rd[EXC_HI:EXC_LO] = exc_q;
            end
            REG_EPC:  rd = {epc_q, 2'b00};
            REG_PRID: rd = PRID;
            default:  rd = '0;
        endcase
    end

    // CP0 register state, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_NORMAL;
            im_q    <= '0;
            ie_q    <= 1'b0;
            bd_q    <= 1'b0;
            ip_q    <= '0;
            exc_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            bd_q    <= bd_d;
            ip_q    <= ip_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end

    // EPC is word aligned, so the low bits of the adjusted PC are dropped
    logic unused_vpc_bits;
    assign unused_vpc_bits = ^vpc_adj[1:0];

    assign io.RD        = rd;
    assign io.EPCOut    = {epc_q, 2'b00};
    assign io.IntReq    = int_req;
    assign io.HandlerPC = HANDLER;
    assign io.DbgState  = state_q;

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: expected values are pushed to a queue as each
// step is driven and popped when the corresponding DUT output is sampled.
module tb_cp0;
    import mips_defs::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];
    logic [31:0] val;

    cp0_if bus ();

    cp0 dut (
        .CLK (clk),
        .RST (rst),
        .io  (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Select a CP0 register and sample the combinational read data
    task automatic read_reg(input logic [4:0] idx, output logic [31:0] v);
        bus.RA = idx;
        #1;
        v = bus.RD;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.WA        = '0;
        bus.WD        = '0;
        bus.WE        = 1'b0;
        bus.ExcCodeIn = '0;
        bus.EXLClr    = 1'b0;
        bus.BDIn      = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.RA = '0;
        bus.VPC = '0;
        bus.HWInt = '0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        expect_val(PRID_DEFAULT); read_reg(REG_PRID, val);  check("reset_prid", val);
        expect_val(32'h0);        read_reg(REG_SR, val);    check("reset_sr", val);
        expect_val(32'h0);        read_reg(REG_CAUSE, val); check("reset_cause", val);
        expect_val(32'h0);        check("reset_epcout", bus.EPCOut);
        expect_val(32'h0);        check("reset_intreq", {31'h0, bus.IntReq});
        expect_val(HANDLER_ADDR); check("handler_pc", bus.HandlerPC);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // mtc0 SR = 0xFC01, visible next cycle
        bus.WE = 1'b1; bus.WA = REG_SR; bus.WD = 32'h0000_FC01;
        tick();
        idle_inputs();
        expect_val(32'h0000_FC01); read_reg(REG_SR, val); check("sr_write", val);

        // Timer0 interrupt: request in the same cycle
        bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3010;
        #1;
        expect_val(32'h1); check("timer_intreq", {31'h0, bus.IntReq});
        tick();
        expect_val(32'h0); check("no_nesting", {31'h0, bus.IntReq});
        expect_val(32'h0000_FC03); read_reg(REG_SR, val);    check("entry_sr", val);
        expect_val(32'h0000_0400); read_reg(REG_CAUSE, val); check("entry_cause", val);
        expect_val(32'h0000_3010); check("entry_epcout", bus.EPCOut);
        expect_val({31'h0, ST_HANDLER}); check("entry_state", {31'h0, bus.DbgState});

        // eret, then RI in a delay slot
        bus.HWInt = '0; bus.EXLClr = 1'b1;
        tick();
        idle_inputs();
        expect_val(32'h0000_FC01); read_reg(REG_SR, val); check("eret_sr", val);
        bus.ExcCodeIn = EXC_RI; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3020;
        #1;
        expect_val(32'h1); check("ri_intreq", {31'h0, bus.IntReq});
        tick();
        idle_inputs();
        expect_val(32'h0000_301C); read_reg(REG_EPC, val);   check("ri_epc", val);
        expect_val(32'h8000_0028); read_reg(REG_CAUSE, val); check("ri_cause", val);

        // eret, then interrupt and Ov together: interrupt wins
        bus.EXLClr = 1'b1;
        tick();
        idle_inputs();
        bus.HWInt = 6'b000010; bus.ExcCodeIn = EXC_OV; bus.VPC = 32'h0000_3030;
        tick();
        idle_inputs();
        bus.HWInt = '0;
        expect_val(32'h0000_0800); read_reg(REG_CAUSE, val); check("prio_cause", val);
        expect_val(32'h0000_3030); read_reg(REG_EPC, val);   check("prio_epc", val);

        // eret + mtc0 SR together while in handler
        bus.EXLClr = 1'b1; bus.WE = 1'b1; bus.WA = REG_SR; bus.WD = 32'h0000_0401;
        #1;
        expect_val(32'h0); check("handler_noreq", {31'h0, bus.IntReq});
        tick();
        idle_inputs();
        expect_val(32'h0000_0401); read_reg(REG_SR, val); check("eret_mtc0_sr", val);

        // Interrupt and mtc0 SR together: the write is discarded
        bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3040;
        bus.WE = 1'b1; bus.WA = REG_SR; bus.WD = 32'h0;
        tick();
        idle_inputs();
        bus.HWInt = '0;
        expect_val(32'h0000_0403); read_reg(REG_SR, val);  check("entry_beats_mtc0", val);
        expect_val(32'h0000_3040); read_reg(REG_EPC, val); check("entry_beats_epc", val);

        // Leave handler with IE = 0, then all interrupts high
        bus.EXLClr = 1'b1; bus.WE = 1'b1; bus.WA = REG_SR; bus.WD = 32'h0000_FC00;
        tick();
        idle_inputs();
        bus.HWInt = 6'b111111;
        #1;
        expect_val(32'h0); check("ie0_intreq", {31'h0, bus.IntReq});
        expect_val(32'h0000_0000); read_reg(REG_CAUSE, val); check("ip_lag_before", val);
        tick();
        expect_val(32'h0000_FC00); read_reg(REG_CAUSE, val); check("ip_lag_after", val);

        // AdEL in a delay slot at VPC = 0: EPC wraps
        bus.ExcCodeIn = EXC_ADEL; bus.BDIn = 1'b1; bus.VPC = 32'h0;
        #1;
        expect_val(32'h1); check("adel_intreq", {31'h0, bus.IntReq});
        tick();
        idle_inputs();
        expect_val(32'hFFFF_FFFC); read_reg(REG_EPC, val);   check("wrap_epc", val);
        expect_val(32'h8000_FC10); read_reg(REG_CAUSE, val); check("adel_cause", val);
        bus.ExcCodeIn = EXC_ADES;
        #1;
        expect_val(32'h0); check("exl_masks_exc", {31'h0, bus.IntReq});
        bus.ExcCodeIn = '0;

        // Cause is read-only; EPC is writable with low bits forced to 0
        bus.WE = 1'b1; bus.WA = REG_CAUSE; bus.WD = 32'hFFFF_FFFF;
        tick();
        bus.WA = REG_EPC; bus.WD = 32'h1234_5677;
        tick();
        idle_inputs();
        expect_val(32'h8000_FC10); read_reg(REG_CAUSE, val); check("cause_ro", val);
        expect_val(32'h1234_5674); check("epc_write", bus.EPCOut);
        expect_val(32'h0); read_reg(5'd3, val); check("unmapped_read", val);

        // Asynchronous reset mid-handler, between edges
        bus.HWInt = 6'b111111;
        #2;
        rst = 1'b1;
        #1;
        expect_val(32'h0); read_reg(REG_SR, val);    check("async_sr", val);
        expect_val(32'h0); read_reg(REG_CAUSE, val); check("async_cause", val);
        expect_val(32'h0); read_reg(REG_EPC, val);   check("async_epc", val);
        expect_val(32'h0); check("async_intreq", {31'h0, bus.IntReq});
        expect_val({31'h0, ST_NORMAL}); check("async_state", {31'h0, bus.DbgState});
        @(negedge clk);
        rst = 1'b0;
        bus.HWInt = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
